// File: rtl/prover_chi_expand.sv
`default_nettype none
// ============================================================================
// prover_chi_expand: builds chi[b] = prod_i (b_i ? w0_i : 1-w0_i) mod F_Q
// in place from a serial MSB-first stream of (w0, 1-w0) pairs.
// Optional macro CHI_SUM_EN adds a post-expansion sum pass on chi_sum.
// Revision: 1.0
// ============================================================================
module prover_chi_expand #(
    parameter int          NBITS   = 3,
    parameter int          F_NBITS = 16,
    parameter logic [63:0] F_Q     = 64'd65521
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [F_NBITS-1:0] w0,
    input  logic [F_NBITS-1:0] m_w0_p1,
    output logic               in_ack,
    output logic               busy,
    output logic               done,
    input  logic [NBITS-1:0]   rd_addr,
    output logic [F_NBITS-1:0] rd_data
`ifdef CHI_SUM_EN
    ,
    output logic [F_NBITS-1:0] chi_sum
`endif
);

    localparam int DEPTH = 1 << NBITS;
    localparam int CW    = $clog2(NBITS + 1);
    localparam logic [2*F_NBITS-1:0] Q_W = (2*F_NBITS)'(F_Q);

`ifdef CHI_SUM_EN
    localparam logic [F_NBITS:0] Q_S = (F_NBITS+1)'(F_Q);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_IN = 3'd1,
        S_EXPAND  = 3'd2,
        S_DONE    = 3'd3,
        S_SUM     = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_IN = 2'd1,
        S_EXPAND  = 2'd2,
        S_DONE    = 2'd3
    } state_t;
`endif

    state_t             state_q;
    logic [F_NBITS-1:0] chi_q [DEPTH];
    logic [F_NBITS-1:0] a1_q;
    logic [F_NBITS-1:0] a0_q;
    logic [CW-1:0]      c_q;
    logic [NBITS-1:0]   j_q;
    logic               armed_q;

    logic [F_NBITS-1:0] chi_j;
    logic [NBITS-1:0]   odd_addr;
    logic [NBITS-1:0]   even_addr;
    logic [F_NBITS-1:0] odd_d;
    logic [F_NBITS-1:0] even_d;

    assign chi_j     = chi_q[j_q];
    assign odd_addr  = {j_q[NBITS-2:0], 1'b1};
    assign even_addr = {j_q[NBITS-2:0], 1'b0};
    assign odd_d  = F_NBITS'(({{F_NBITS{1'b0}}, chi_j} * {{F_NBITS{1'b0}}, a1_q}) % Q_W);
    assign even_d = F_NBITS'(({{F_NBITS{1'b0}}, chi_j} * {{F_NBITS{1'b0}}, a0_q}) % Q_W);

`ifdef CHI_SUM_EN
    logic [NBITS-1:0]   sum_idx_q;
    logic [F_NBITS-1:0] acc_q;
    logic [F_NBITS-1:0] acc_d;

    assign acc_d = F_NBITS'(({1'b0, acc_q} + {1'b0, chi_q[sum_idx_q]}) % Q_S);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            in_ack  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_data <= '0;
            a1_q    <= '0;
            a0_q    <= '0;
            c_q     <= '0;
            j_q     <= '0;
            armed_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                chi_q[i] <= '0;
            end
`ifdef CHI_SUM_EN
            sum_idx_q <= '0;
            acc_q     <= '0;
            chi_sum   <= '0;
`endif
        end else begin
            in_ack  <= 1'b0;
            rd_data <= chi_q[rd_addr];
            // A held in_valid must drop before the next pair can be accepted.
            if (!in_valid) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_WAIT_IN;
                        c_q      <= '0;
                        chi_q[0] <= F_NBITS'(1);
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid && armed_q) begin
                        a1_q    <= w0;
                        a0_q    <= m_w0_p1;
                        in_ack  <= 1'b1;
                        armed_q <= 1'b0;
                        j_q     <= (NBITS'(1) << c_q) - NBITS'(1);
                        state_q <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    // Descending j keeps chi[j] unread-after-write within the pass.
                    chi_q[odd_addr]  <= odd_d;
                    chi_q[even_addr] <= even_d;
                    if (j_q == '0) begin
                        c_q <= c_q + CW'(1);
                        if (c_q == CW'(NBITS - 1)) begin
                            busy <= 1'b0;
`ifdef CHI_SUM_EN
                            state_q   <= S_SUM;
                            sum_idx_q <= '0;
                            acc_q     <= '0;
`else
                            state_q <= S_DONE;
                            done    <= 1'b1;
`endif
                        end else begin
                            state_q <= S_WAIT_IN;
                        end
                    end else begin
                        j_q <= j_q - NBITS'(1);
                    end
                end
`ifdef CHI_SUM_EN
                S_SUM: begin
                    acc_q     <= acc_d;
                    sum_idx_q <= sum_idx_q + NBITS'(1);
                    if (sum_idx_q == {NBITS{1'b1}}) begin
                        chi_sum <= acc_d;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prover_chi_expand.sv
`default_nettype none
// Bench for prover_chi_expand: NBITS=3 and NBITS=2 instances, read-port scoreboard.
module tb_prover_chi_expand;

    localparam logic [15:0] Q = 16'd65521;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start3 = 0, iv3 = 0, ack3, busy3, done3;
    logic [15:0] w3 = 0, m3 = 0, rd3;
    logic [2:0]  ra3 = 0;
    logic        start2 = 0, iv2 = 0, ack2, busy2, done2;
    logic [15:0] w2 = 0, m2 = 0, rd2;
    logic [1:0]  ra2 = 0;
`ifdef CHI_SUM_EN
    logic [15:0] sum3, sum2;
`endif

    prover_chi_expand #(.NBITS(3), .F_NBITS(16), .F_Q(64'd65521)) u3 (
        .clk(clk), .rst(rst), .start(start3), .in_valid(iv3), .w0(w3), .m_w0_p1(m3),
        .in_ack(ack3), .busy(busy3), .done(done3), .rd_addr(ra3), .rd_data(rd3)
`ifdef CHI_SUM_EN
        , .chi_sum(sum3)
`endif
    );

    prover_chi_expand #(.NBITS(2), .F_NBITS(16), .F_Q(64'd65521)) u2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(iv2), .w0(w2), .m_w0_p1(m2),
        .in_ack(ack2), .busy(busy2), .done(done2), .rd_addr(ra2), .rd_data(rd2)
`ifdef CHI_SUM_EN
        , .chi_sum(sum2)
`endif
    );

    int passed = 0;
    int total  = 0;
    logic [15:0] exp_q[$];
    logic [15:0] pw[3];
    logic [15:0] pm[3];
    int ack_cnt = 0;
    int exp_cnt = 0;

    always @(negedge clk) begin
        if (ack3) ack_cnt++;
        if (int'(u3.state_q) == 2) exp_cnt++;
    end

    // Direct product form of the basis: first pair drives the index MSB.
    function automatic logic [15:0] model(input int n, input int b);
        logic [31:0] acc;
        acc = 32'd1;
        for (int k = 0; k < n; k++) begin
            acc = (acc * 32'(((b >> (n - 1 - k)) & 1) != 0 ? pw[k] : pm[k])) % 32'(Q);
        end
        return acc[15:0];
    endfunction

    function automatic logic [15:0] one_minus(input logic [15:0] w);
        return (w <= 16'd1) ? (16'd1 - w) : (Q + 16'd1 - w);
    endfunction

    task automatic pulse_start3();
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
    endtask

    task automatic feed3(input logic [15:0] w, input logic [15:0] m);
        int t = 0;
        w3 = w; m3 = m; iv3 = 1'b1;
        @(negedge clk);
        while (!ack3 && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (ack3 !== 1'b1) $display("FAIL handshake3: in_ack=%b required 1", ack3);
        else passed++;
        iv3 = 1'b0;
        @(negedge clk);
    endtask

    task automatic feed2(input logic [15:0] w, input logic [15:0] m);
        int t = 0;
        w2 = w; m2 = m; iv2 = 1'b1;
        @(negedge clk);
        while (!ack2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (ack2 !== 1'b1) $display("FAIL handshake2: in_ack=%b required 1", ack2);
        else passed++;
        iv2 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done3();
        int t = 0;
        while (!done3 && t < 60) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (done3 !== 1'b1) $display("FAIL done_timeout: done=%b required 1", done3);
        else passed++;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        repeat (3) @(negedge clk);
        total += 4;
        if (busy3 !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy3); else passed++;
        if (done3 !== 1'b0) $display("FAIL reset_done: got %b required 0", done3); else passed++;
        if (ack3 !== 1'b0)  $display("FAIL reset_ack: got %b required 0", ack3); else passed++;
        if (rd3 !== 16'd0)  $display("FAIL reset_rd: got %0d required 0", rd3); else passed++;
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            ra3 = a[2:0];
            exp_q.push_back(16'd0);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (rd3 !== e) $display("FAIL reset_tbl[%0d]: got %0d required %0d", a, rd3, e); else passed++;
        end
    endtask

    task automatic test_zero_w0();
        int a0, e0;
        logic [15:0] e;
        pulse_start3();
        a0 = ack_cnt; e0 = exp_cnt;
        for (int k = 0; k < 3; k++) begin
            pw[k] = 16'd0; pm[k] = 16'd1;
            feed3(pw[k], pm[k]);
        end
        wait_done3();
        total += 3;
        if (ack_cnt - a0 != 3) $display("FAIL zero_ackcnt: got %0d required 3", ack_cnt - a0); else passed++;
        if (exp_cnt - e0 != 7) $display("FAIL zero_expcnt: got %0d required 7", exp_cnt - e0); else passed++;
        if (busy3 !== 1'b0) $display("FAIL zero_busy: got %b required 0", busy3); else passed++;
        for (int a = 0; a < 8; a++) begin
            ra3 = a[2:0];
            exp_q.push_back(model(3, a));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (rd3 !== e) $display("FAIL zero_tbl[%0d]: got %0d required %0d", a, rd3, e); else passed++;
        end
    endtask

    task automatic test_two_bits();
        int t = 0;
        logic [15:0] e;
        logic [15:0] ref2[4];
        ref2[0] = 16'd2; ref2[1] = Q - 16'd3; ref2[2] = Q - 16'd4; ref2[3] = 16'd6;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        feed2(16'd2, Q - 16'd1);
        feed2(16'd3, Q - 16'd2);
        while (!done2 && t < 40) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (done2 !== 1'b1) $display("FAIL two_done: got %b required 1", done2); else passed++;
        for (int a = 0; a < 4; a++) begin
            ra2 = a[1:0];
            exp_q.push_back(ref2[a]);
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (rd2 !== e) $display("FAIL two_tbl[%0d]: got %0d required %0d", a, rd2, e); else passed++;
        end
    endtask

    task automatic test_held_valid();
        int a0;
        logic [15:0] e;
        pulse_start3();
        total += 2;
        if (done3 !== 1'b0) $display("FAIL held_done_fall: got %b required 0", done3); else passed++;
        if (busy3 !== 1'b1) $display("FAIL held_busy_rise: got %b required 1", busy3); else passed++;
        a0 = ack_cnt;
        w3 = 16'd1; m3 = 16'd0; iv3 = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (ack_cnt - a0 != 1) $display("FAIL held_single_ack: got %0d required 1", ack_cnt - a0); else passed++;
        iv3 = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            pw[k] = 16'd1; pm[k] = 16'd0;
        end
        feed3(16'd1, 16'd0);
        feed3(16'd1, 16'd0);
        wait_done3();
        for (int a = 0; a < 8; a++) begin
            ra3 = a[2:0];
            exp_q.push_back(model(3, a));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (rd3 !== e) $display("FAIL held_tbl[%0d]: got %0d required %0d", a, rd3, e); else passed++;
        end
    endtask

    task automatic test_stall_start();
        int a0;
        bit busy_ok;
        logic [15:0] e;
        for (int k = 0; k < 3; k++) begin
            pw[k] = 16'($urandom_range(0, 65520));
            pm[k] = 16'($urandom_range(0, 65520));
        end
        pulse_start3();
        feed3(pw[0], pm[0]);
        feed3(pw[1], pm[1]);
        pulse_start3();
        a0 = ack_cnt;
        busy_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy3 !== 1'b1) busy_ok = 1'b0;
        end
        total += 2;
        if (!busy_ok) $display("FAIL stall_busy: got 0 required 1"); else passed++;
        if (ack_cnt != a0) $display("FAIL stall_ack: got %0d required 0", ack_cnt - a0); else passed++;
        feed3(pw[2], pm[2]);
        wait_done3();
        for (int a = 0; a < 8; a++) begin
            ra3 = a[2:0];
            exp_q.push_back(model(3, a));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (rd3 !== e) $display("FAIL stall_tbl[%0d]: got %0d required %0d", a, rd3, e); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int a0;
        logic [15:0] e;
        pulse_start3();
        for (int k = 0; k < 3; k++) begin
            feed3(16'($urandom_range(0, 65520)), 16'($urandom_range(0, 65520)));
        end
        rst = 1'b1;
        #1;
        total += 4;
        if (busy3 !== 1'b0) $display("FAIL rstmid_busy: got %b required 0", busy3); else passed++;
        if (done3 !== 1'b0) $display("FAIL rstmid_done: got %b required 0", done3); else passed++;
        if (ack3 !== 1'b0)  $display("FAIL rstmid_ack: got %b required 0", ack3); else passed++;
        if (rd3 !== 16'd0)  $display("FAIL rstmid_rd: got %0d required 0", rd3); else passed++;
        a0 = ack_cnt;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (ack_cnt != a0) $display("FAIL rstmid_noack: got %0d required 0", ack_cnt - a0); else passed++;
        for (int k = 0; k < 3; k++) begin
            pw[k] = 16'($urandom_range(0, 65520));
            pm[k] = one_minus(pw[k]);
        end
        pulse_start3();
        for (int k = 0; k < 3; k++) feed3(pw[k], pm[k]);
        wait_done3();
        for (int a = 0; a < 8; a++) begin
            ra3 = a[2:0];
            exp_q.push_back(model(3, a));
            @(negedge clk);
            e = exp_q.pop_front();
            total++;
            if (rd3 !== e) $display("FAIL rstmid_tbl[%0d]: got %0d required %0d", a, rd3, e); else passed++;
        end
    endtask

`ifdef CHI_SUM_EN
    task automatic test_chi_sum();
        pulse_start3();
        for (int k = 0; k < 3; k++) begin
            pw[k] = 16'($urandom_range(0, 65520));
            feed3(pw[k], one_minus(pw[k]));
        end
        wait_done3();
        total++;
        if (sum3 !== 16'd1) $display("FAIL chi_sum: got %0d required 1", sum3); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_zero_w0();
        test_two_bits();
        test_held_valid();
        test_stall_start();
        test_reset_mid();
`ifdef CHI_SUM_EN
        test_chi_sum();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
